// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register, LEGv8 decoder and ID/EX bundle register.
// Register-file addresses are driven combinationally from the held instruction.
// A small FSM inserts at most one load-use bubble per instruction and applies the
// flush/stall handshake between fetch and execute.
module decode_stage #(
   parameter int PC_W   = 64,
   parameter int DATA_W = 64
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [PC_W-1:0]   if_pc,
   output logic              if_ready,
   input  logic              flush,
   input  logic              ex_stall,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rd,
   output logic [4:0]        read1,
   output logic [4:0]        read2,
   output logic [4:0]        write_reg,
   output logic              id_valid,
   output logic [PC_W-1:0]   id_pc,
   output logic [DATA_W-1:0] id_imm,
   output logic [4:0]        id_rd,
   output logic              REGWRITE,
   output logic              MEMREAD,
   output logic              MEMWRITE,
   output logic              MEMTOREG,
   output logic              ALUSRC,
   output logic              BRANCH,
   output logic              UNCOND,
   output logic [1:0]        ALUOP,
   output logic              id_illegal
);

   typedef enum logic [1:0] {EMPTY, FULL, BUBBLED} state_t;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       alusrc;
      logic       branch;
      logic       uncond;
      logic [1:0] aluop;
      logic       illegal;
   } ctrl_t;

   state_t            state, next_state;
   logic [31:0]       instr_q;
   logic [PC_W-1:0]   pc_q;
   ctrl_t             dec_ctrl, ctrl_q;
   logic [DATA_W-1:0] dec_imm;
   logic              uses_rn, uses_rm, uses_rt, is_stur_cbz;
   logic              hazard, capture, issue, bubble;

   // Register-file ports come straight from the held instruction.
   assign read1     = instr_q[9:5];
   assign read2     = is_stur_cbz ? instr_q[4:0] : instr_q[20:16];
   assign write_reg = instr_q[4:0];

   // Decode the held instruction into controls, immediate and source usage.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
      dec_ctrl    = '0;
      dec_imm     = '0;
      uses_rn     = 1'b0;
      uses_rm     = 1'b0;
      uses_rt     = 1'b0;
      is_stur_cbz = 1'b0;
      if (instr_q[31:21] == 11'b10001011000 || instr_q[31:21] == 11'b11001011000 ||
          instr_q[31:21] == 11'b10001010000 || instr_q[31:21] == 11'b10101010000) begin
         dec_ctrl.regwrite = 1'b1;
         dec_ctrl.aluop    = 2'b10;
         uses_rn           = 1'b1;
         uses_rm           = 1'b1;
      end else if (instr_q[31:22] == 10'b1001000100) begin
         dec_ctrl.regwrite = 1'b1;
         dec_ctrl.alusrc   = 1'b1;
         dec_imm           = {{(DATA_W-12){1'b0}}, instr_q[21:10]};
         uses_rn           = 1'b1;
      end else if (instr_q[31:21] == 11'b11111000010) begin
         dec_ctrl.regwrite = 1'b1;
         dec_ctrl.memread  = 1'b1;
         dec_ctrl.memtoreg = 1'b1;
         dec_ctrl.alusrc   = 1'b1;
         dec_imm           = {{(DATA_W-9){instr_q[20]}}, instr_q[20:12]};
         uses_rn           = 1'b1;
      end else if (instr_q[31:21] == 11'b11111000000) begin
         dec_ctrl.memwrite = 1'b1;
         dec_ctrl.alusrc   = 1'b1;
         dec_imm           = {{(DATA_W-9){instr_q[20]}}, instr_q[20:12]};
         uses_rn           = 1'b1;
         uses_rt           = 1'b1;
         is_stur_cbz       = 1'b1;
      end else if (instr_q[31:24] == 8'b10110100) begin
         dec_ctrl.branch   = 1'b1;
         dec_ctrl.aluop    = 2'b01;
         dec_imm           = {{(DATA_W-19){instr_q[23]}}, instr_q[23:5]};
         uses_rt           = 1'b1;
         is_stur_cbz       = 1'b1;
      end else if (instr_q[31:26] == 6'b000101) begin
         dec_ctrl.uncond   = 1'b1;
         dec_imm           = {{(DATA_W-26){instr_q[25]}}, instr_q[25:0]};
      end else begin
         dec_ctrl.illegal  = 1'b1;
      end
   end

   // Load-use hazard: a source actually read by the held instruction is the pending load target.
   assign hazard = ex_memread && (ex_rd != 5'd31) &&
                   ((uses_rn && instr_q[9:5]   == ex_rd) ||
                    (uses_rm && instr_q[20:16] == ex_rd) ||
                    (uses_rt && instr_q[4:0]   == ex_rd));

   // Next state, fetch handshake and ID/EX load selection.
   always_comb begin
      next_state = state;
      if_ready   = 1'b0;
      capture    = 1'b0;
      issue      = 1'b0;
      bubble     = 1'b0;
      if (RESET) begin
         if_ready = 1'b0;
      end else if (flush) begin
         if_ready   = 1'b1;
         bubble     = 1'b1;
         next_state = EMPTY;
      end else if (!ex_stall) begin
         if (state == EMPTY) begin
            if_ready = 1'b1;
            bubble   = 1'b1;
            if (if_valid) begin
               capture    = 1'b1;
               next_state = FULL;
            end
         end else if (state == FULL && hazard) begin
            bubble     = 1'b1;
            next_state = BUBBLED;
         end else begin
            // FULL without hazard, or BUBBLED (hazard already paid once).
            if_ready   = 1'b1;
            issue      = 1'b1;
            capture    = if_valid;
            next_state = if_valid ? FULL : EMPTY;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or posedge RESET) begin
      // NOTE: state elements use non-blocking assignments so all registers update together at the edge.
      if (RESET) state <= EMPTY;
      else       state <= next_state;
   end

   // IF/ID register: captures only when fetch is accepted.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         instr_q <= '0;
         pc_q    <= '0;
      end else if (capture) begin
         instr_q <= if_instr;
         pc_q    <= if_pc;
      end
   end

   // ID/EX register: loads the decoded bundle, a bubble, or holds during a stall.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_imm   <= '0;
         id_rd    <= '0;
         ctrl_q   <= '0;
      end else if (bubble) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_imm   <= '0;
         id_rd    <= '0;
         ctrl_q   <= '0;
      end else if (issue) begin
         id_valid <= 1'b1;
         id_pc    <= pc_q;
         id_imm   <= dec_imm;
         id_rd    <= instr_q[4:0];
         ctrl_q   <= dec_ctrl;
      end
   end

   assign REGWRITE   = ctrl_q.regwrite;
   assign MEMREAD    = ctrl_q.memread;
   assign MEMWRITE   = ctrl_q.memwrite;
   assign MEMTOREG   = ctrl_q.memtoreg;
   assign ALUSRC     = ctrl_q.alusrc;
   assign BRANCH     = ctrl_q.branch;
   assign UNCOND     = ctrl_q.uncond;
   assign ALUOP      = ctrl_q.aluop;
   assign id_illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expectations.
module tb_decode_stage;

   localparam int PC_W   = 64;
   localparam int DATA_W = 64;

   // Instruction encodings
   localparam logic [31:0] I_ADD    = 32'h8B020023; // ADD  X3,X1,X2
   localparam logic [31:0] I_ADD6   = 32'h8B0200A6; // ADD  X6,X5,X2
   localparam logic [31:0] I_ADD31  = 32'h8B0203E6; // ADD  X6,X31,X2
   localparam logic [31:0] I_LDUR   = 32'hF85F8025; // LDUR X5,[X1,#-8]
   localparam logic [31:0] I_LDUR31 = 32'hF85F803F; // LDUR X31,[X1,#-8]
   localparam logic [31:0] I_CBZ    = 32'hB4FFFF87; // CBZ  X7,#-4
   localparam logic [31:0] I_ADDI   = 32'h913FFC89; // ADDI X9,X4,#0xFFF
   localparam logic [31:0] I_STUR   = 32'hF8004062; // STUR X2,[X3,#4]
   localparam logic [31:0] I_B      = 32'h17FFFFFF; // B    #-1
   localparam logic [31:0] I_BAD    = 32'hFFFFFFFF;

   // Expected control vectors {RW,MR,MW,MTR,AS,BR,UN,ALUOP}
   localparam logic [8:0] C_R    = 9'h102;
   localparam logic [8:0] C_LDUR = 9'h1B0;
   localparam logic [8:0] C_ADDI = 9'h110;
   localparam logic [8:0] C_STUR = 9'h050;
   localparam logic [8:0] C_CBZ  = 9'h009;
   localparam logic [8:0] C_B    = 9'h004;
   localparam logic [8:0] C_NONE = 9'h000;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              if_valid;
   logic [31:0]       if_instr;
   logic [PC_W-1:0]   if_pc;
   logic              if_ready;
   logic              flush, ex_stall, ex_memread;
   logic [4:0]        ex_rd;
   logic [4:0]        read1, read2, write_reg;
   logic              id_valid;
   logic [PC_W-1:0]   id_pc;
   logic [DATA_W-1:0] id_imm;
   logic [4:0]        id_rd;
   logic              REGWRITE, MEMREAD, MEMWRITE, MEMTOREG, ALUSRC, BRANCH, UNCOND;
   logic [1:0]        ALUOP;
   logic              id_illegal;
   logic [8:0]        ctrl;

   int checks = 0;
   int errors = 0;

   decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
      .flush(flush), .ex_stall(ex_stall), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .read1(read1), .read2(read2), .write_reg(write_reg),
      .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_rd(id_rd),
      .REGWRITE(REGWRITE), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .MEMTOREG(MEMTOREG),
      .ALUSRC(ALUSRC), .BRANCH(BRANCH), .UNCOND(UNCOND), .ALUOP(ALUOP),
      .id_illegal(id_illegal)
   );

   assign ctrl = {REGWRITE, MEMREAD, MEMWRITE, MEMTOREG, ALUSRC, BRANCH, UNCOND, ALUOP};

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [PC_W-1:0] pc);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
   endtask

   task automatic idle();
      if_valid = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      flush = 1'b0; ex_stall = 1'b0; ex_memread = 1'b0; ex_rd = '0;
      #1;
      check("rst_if_ready", 64'(if_ready), 64'd0);
      check("rst_id_valid", 64'(id_valid), 64'd0);
      check("rst_ctrl", 64'(ctrl), 64'(C_NONE));
      check("rst_read1", 64'(read1), 64'd0);
      tick();
      tick();
      RESET = 1'b0;
      #1;
      check("empty_if_ready", 64'(if_ready), 64'd1);

      // ADD X3,X1,X2 at 0x10
      present(I_ADD, 64'h10);
      tick();
      idle();
      check("add_read1", 64'(read1), 64'd1);
      check("add_read2", 64'(read2), 64'd2);
      check("add_write_reg", 64'(write_reg), 64'd3);
      check("add_not_yet_valid", 64'(id_valid), 64'd0);
      #1;
      check("add_full_ready", 64'(if_ready), 64'd1);
      tick();
      check("add_valid", 64'(id_valid), 64'd1);
      check("add_ctrl", 64'(ctrl), 64'(C_R));
      check("add_rd", 64'(id_rd), 64'd3);
      check("add_pc", id_pc, 64'h10);
      check("add_imm", id_imm, 64'd0);
      check("add_illegal", 64'(id_illegal), 64'd0);
      tick();
      check("add_drain_valid", 64'(id_valid), 64'd0);

      // LDUR X5 then dependent ADD X6,X5,X2: one bubble
      present(I_LDUR, 64'h20);
      tick();
      present(I_ADD6, 64'h24);
      tick();
      idle();
      check("ldur_valid", 64'(id_valid), 64'd1);
      check("ldur_ctrl", 64'(ctrl), 64'(C_LDUR));
      check("ldur_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      check("ldur_rd", 64'(id_rd), 64'd5);
      ex_memread = 1'b1; ex_rd = 5'd5;
      #1;
      check("haz_if_ready", 64'(if_ready), 64'd0);
      check("haz_read1", 64'(read1), 64'd5);
      tick();
      check("bubble_valid", 64'(id_valid), 64'd0);
      check("bubble_ctrl", 64'(ctrl), 64'(C_NONE));
      check("bubbled_if_ready", 64'(if_ready), 64'd1);
      check("bubbled_read1", 64'(read1), 64'd5);
      tick();
      check("add6_valid", 64'(id_valid), 64'd1);
      check("add6_rd", 64'(id_rd), 64'd6);
      check("add6_pc", id_pc, 64'h24);
      check("add6_ctrl", 64'(ctrl), 64'(C_R));
      ex_memread = 1'b0;
      tick();
      check("add6_drain", 64'(id_valid), 64'd0);

      // Same with register 31: no bubble
      present(I_LDUR31, 64'h30);
      tick();
      present(I_ADD31, 64'h34);
      tick();
      idle();
      check("ldur31_rd", 64'(id_rd), 64'd31);
      ex_memread = 1'b1; ex_rd = 5'd31;
      #1;
      check("x31_if_ready", 64'(if_ready), 64'd1);
      tick();
      check("x31_valid", 64'(id_valid), 64'd1);
      check("x31_rd", 64'(id_rd), 64'd6);
      check("x31_pc", id_pc, 64'h34);
      ex_memread = 1'b0;
      tick();

      // Back-to-back CBZ, ADDI, STUR, B, illegal
      present(I_CBZ, 64'h40);
      tick();
      present(I_ADDI, 64'h44);
      check("cbz_read2", 64'(read2), 64'd7);
      check("cbz_write_reg", 64'(write_reg), 64'd7);
      tick();
      check("cbz_ctrl", 64'(ctrl), 64'(C_CBZ));
      check("cbz_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      check("cbz_pc", id_pc, 64'h40);
      check("addi_read1", 64'(read1), 64'd4);
      check("addi_write_reg", 64'(write_reg), 64'd9);
      present(I_STUR, 64'h48);
      tick();
      check("addi_ctrl", 64'(ctrl), 64'(C_ADDI));
      check("addi_imm", id_imm, 64'h0000_0000_0000_0FFF);
      check("stur_read1", 64'(read1), 64'd3);
      check("stur_read2", 64'(read2), 64'd2);
      present(I_B, 64'h4C);
      tick();
      check("stur_ctrl", 64'(ctrl), 64'(C_STUR));
      check("stur_imm", id_imm, 64'd4);
      present(I_BAD, 64'h50);
      tick();
      check("b_ctrl", 64'(ctrl), 64'(C_B));
      check("b_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      idle();
      tick();
      check("bad_valid", 64'(id_valid), 64'd1);
      check("bad_illegal", 64'(id_illegal), 64'd1);
      check("bad_ctrl", 64'(ctrl), 64'(C_NONE));

      // Stall for three cycles with FULL state
      present(I_ADD, 64'h60);
      tick();
      present(I_ADD6, 64'h64);
      tick();
      present(I_CBZ, 64'h68);
      ex_stall = 1'b1;
      #1;
      check("stall_if_ready", 64'(if_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", 64'(id_valid), 64'd1);
         check("stall_pc", id_pc, 64'h60);
         check("stall_rd", 64'(id_rd), 64'd3);
         check("stall_read1", 64'(read1), 64'd5);
         check("stall_if_ready_hold", 64'(if_ready), 64'd0);
      end
      ex_stall = 1'b0;
      idle();
      #1;
      check("unstall_if_ready", 64'(if_ready), 64'd1);
      tick();
      check("unstall_pc", id_pc, 64'h64);
      check("unstall_rd", 64'(id_rd), 64'd6);
      tick();

      // Flush during a hazard: no bubble replay, same-cycle fetch dropped
      present(I_LDUR, 64'h70);
      tick();
      present(I_ADD6, 64'h74);
      tick();
      present(I_CBZ, 64'h78);
      ex_memread = 1'b1; ex_rd = 5'd5; flush = 1'b1;
      #1;
      check("flush_if_ready", 64'(if_ready), 64'd1);
      tick();
      check("flush_valid", 64'(id_valid), 64'd0);
      check("flush_ctrl", 64'(ctrl), 64'(C_NONE));
      flush = 1'b0; ex_memread = 1'b0; idle();
      #1;
      check("flush_empty_ready", 64'(if_ready), 64'd1);
      tick();
      check("flush_no_replay", 64'(id_valid), 64'd0);

      // Reset pulse while BUBBLED
      present(I_LDUR, 64'h80);
      tick();
      present(I_ADD6, 64'h84);
      tick();
      idle();
      ex_memread = 1'b1; ex_rd = 5'd5;
      tick();
      check("pre_rst_bubble", 64'(id_valid), 64'd0);
      check("pre_rst_read1", 64'(read1), 64'd5);
      #2;
      RESET = 1'b1;
      #1;
      check("async_rst_read1", 64'(read1), 64'd0);
      check("async_rst_write_reg", 64'(write_reg), 64'd0);
      check("async_rst_if_ready", 64'(if_ready), 64'd0);
      check("async_rst_ctrl", 64'(ctrl), 64'(C_NONE));
      check("async_rst_pc", id_pc, 64'd0);
      tick();
      RESET = 1'b0; ex_memread = 1'b0;
      #1;
      check("post_rst_ready", 64'(if_ready), 64'd1);
      tick();
      check("post_rst_valid", 64'(id_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID pipeline register plus LEGv8 decoder.
- Drives register-file read/write addresses combinationally from the held instruction and produces the registered ID/EX control, immediate and PC bundle for the execute stage.
- Contains a one-shot load-use interlock and the flush/stall handshake between fetch and execute.

Parameters:
- PC_W, 64, program counter width
- DATA_W, 64, immediate/datapath width

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  PC_W  PC of if_instr
- if_ready  out  1  decode accepts the instruction this cycle
- flush  in  1  taken branch; kill IF/ID and ID/EX contents
- ex_stall  in  1  execute cannot accept; freeze the stage
- ex_memread  in  1  instruction in EX is LDUR
- ex_rd  in  5  destination of the instruction in EX
- read1  out  5  register-file read address 1 = held instr[9:5]
- read2  out  5  register-file read address 2: instr[4:0] for STUR/CBZ, otherwise instr[20:16]
- write_reg  out  5  held instr[4:0]
- id_valid  out  1  ID/EX bundle valid
- id_pc  out  PC_W  PC of the decoded instruction
- id_imm  out  DATA_W  extended immediate, unshifted
- id_rd  out  5  destination register
- REGWRITE, MEMREAD, MEMWRITE, MEMTOREG, ALUSRC, BRANCH, UNCOND  out  1 each  control signals
- ALUOP  out  2  ALU operation class
- id_illegal  out  1  undecodable opcode

Behaviour:
- Reset (async, while RESET=1):
  - All registered outputs are 0.
  - IF/ID valid is 0; FSM is EMPTY.
  - if_ready is 0 while RESET=1 and follows the rules below once RESET falls.
- Decode table (opcode fields → controls; ALUOP):
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: REGWRITE; ALUOP=10; imm=0.
  - ADDI instr[31:22]=1001000100: REGWRITE, ALUSRC; ALUOP=00; imm = zero-extended [21:10].
  - LDUR 11111000010: REGWRITE, MEMREAD, MEMTOREG, ALUSRC; ALUOP=00; imm = sign-extended [20:12].
  - STUR 11111000000: MEMWRITE, ALUSRC; ALUOP=00; imm = sign-extended [20:12].
  - CBZ instr[31:24]=10110100: BRANCH; ALUOP=01; imm = sign-extended [23:5].
  - B instr[31:26]=000101: UNCOND; imm = sign-extended [25:0].
  - Any other encoding: all controls 0, id_illegal=1, id_valid=1.
- Source usage for hazard checks:
  - R-type: rn, rm.
  - ADDI/LDUR: rn.
  - STUR: rn, rt.
  - CBZ: rt.
  - B: none.
- FSM states: EMPTY, FULL, BUBBLED.
  - EMPTY: if_ready=1. if_valid captures instr/pc and moves to FULL.
  - FULL: evaluate hazard. Hazard = ex_memread & ex_rd≠31 & a used source equals ex_rd.
    - Hazard: ID/EX loads a bubble (id_valid=0, all controls 0), IF/ID holds, if_ready=0, next state BUBBLED.
    - No hazard: ID/EX loads the decoded bundle with id_valid=1 and if_ready=1. A new fetch stays in FULL; otherwise go to EMPTY.
  - BUBBLED: hazard is ignored (one bubble per instruction, no repeat stalls). Issue as FULL/no-hazard.
- ex_stall=1: IF/ID, ID/EX and FSM all hold, if_ready=0, no hazard evaluation.
- flush=1 (synchronous):
  - Next edge clears IF/ID valid and ID/EX (id_valid=0, controls 0); FSM goes to EMPTY.
  - Any instruction presented the same cycle is dropped; if_ready=1.
- Priority: RESET > flush > ex_stall > hazard > normal issue.
- Latency: an instruction accepted at edge N drives read1/read2/write_reg after N. Its bundle appears at edge N+1, or N+2 when hazarded.
- Register 31: write_reg=31 issues normally (the register file discards the write); ex_rd=31 never triggers a hazard.
- RESET asserted mid-stall or mid-bubble returns to EMPTY immediately.

Test Plan:
- Reset, then ADD X3,X1,X2 (0x8B020023) at pc=0x10 → next cycle read1=1, read2=2; one edge later REGWRITE=1, ALUOP=10, id_rd=3, id_pc=0x10, id_valid=1.
- LDUR X5,[X1,#-8] then ADD X6,X5,X2 with ex_memread=1, ex_rd=5 → exactly one bubble (id_valid=0), if_ready=0 for one cycle, ADD issues next cycle.
- Same sequence with ex_rd=31 → no bubble.
- CBZ X7,#-4 → read2=7, BRANCH=1, ALUOP=01, id_imm=0xFFFF_FFFF_FFFF_FFFC.
- ex_stall high 3 cycles with FULL state → all outputs frozen, if_ready=0; flush during a hazard → EMPTY, id_valid=0, no bubble replay.
- Opcode 0xFFFFFFFF → id_illegal=1, controls 0; RESET pulse mid-BUBBLED → all outputs 0 asynchronously.
